pool1_window_reader: RTL and testbench

// - Reads pool1 feature maps (20 ch x 12x12, 8-bit) back out of result BRAM after max pooling has stored them.
// - Emits them as a 5x5xC conv2 input-window stream on a valid/ready interface to the conv2 PE array.
// - Pipelined BRAM reads with a credit-limited output FIFO; full rate when data_ready stays high.

---
 rtl/pool1_window_reader.sv | 187 ++++++++++++++++++
 tb/tb_pool1_window_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool1_window_reader.sv
// pool1_window_reader: streams conv2 input windows out of the result BRAM.
// Walks oy, ox, ch, ky, kx (outer to inner) and issues at most one BRAM read
// per cycle. Each read is tracked through an RD_LAT-deep pipe and lands in a
// small output FIFO. Reads are credit-limited, so the FIFO can never overflow.
// Optional build macro POOL1_RD_PAD_EN adds a zero pad of (KSIZE-1)/2 on every
// side. Pad slots take a pipe slot but do not read the BRAM.
// The FSM state is exported on state_dbg for checkers.
//
// Handshake: an element transfers on a rising clk edge where
// data_valid && data_ready. While data_valid is high and data_ready is low,
// data_out and data_last hold. data_valid never drops without a transfer.
module pool1_window_reader #(
  parameter int POOL1_BASE = 11520,
  parameter int POOL1_DEEP = 20,
  parameter int POOL1_SIZE = 12,
  parameter int KSIZE      = 5,
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pool1_rd_en,
  output logic                 result_bram_ena,
  output logic [14:0]          result_bram_addra,
  input  logic [DATA_SIZE-1:0] result_bram_douta,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 data_last,
  output logic                 pool1_rd_finish,
  output logic [1:0]           state_dbg
);
`ifdef POOL1_RD_PAD_EN
  localparam int PAD = (KSIZE - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int OUT = POOL1_SIZE - KSIZE + 1 + 2 * PAD;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);
  localparam logic [7:0]    OUT_MAX = 8'(OUT - 1);
  localparam logic [7:0]    CH_MAX  = 8'(POOL1_DEEP - 1);
  localparam logic [7:0]    K_MAX   = 8'(KSIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t state, state_n;

  logic [7:0]           oy, ox, ch, ky, kx;
  logic [RD_LAT-1:0]    pipe_v, pipe_l;
`ifdef POOL1_RD_PAD_EN
  logic [RD_LAT-1:0]    pipe_z;
`endif
  logic [CW-1:0]        out_cnt, fifo_cnt;
  logic [DATA_SIZE:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_SIZE:0]   head;
  logic [DATA_SIZE-1:0] push_data;
  logic [CW:0]          used;
  logic                 slot, pad_slot, last_flag, pass_end, push, fifo_pop;
  int                   iy, ix;

  assign data_valid = (fifo_cnt != '0);
  assign head       = fifo_mem[rd_ptr];
  assign data_out   = data_valid ? head[DATA_SIZE-1:0] : '0;
  assign data_last  = data_valid & head[DATA_SIZE];
  assign push       = pipe_v[RD_LAT-1];
  assign state_dbg  = state;
`ifdef POOL1_RD_PAD_EN
  assign push_data  = pipe_z[RD_LAT-1] ? '0 : result_bram_douta;
`else
  assign push_data  = result_bram_douta;
`endif

  // Slot issue, address generation and next-state logic.
  always_comb begin
    state_n           = state;
    pool1_rd_finish   = 1'b0;
    fifo_pop          = data_valid && data_ready;
    // A pop in this cycle frees its entry by the same edge that accepts a new
    // issue, so it is credited here. This keeps one element per cycle with
    // FIFO_DEPTH = RD_LAT + 1.
    used              = {1'b0, out_cnt} + {1'b0, fifo_cnt} - {{CW{1'b0}}, fifo_pop};
    slot              = (state == S_ISSUE) && pool1_rd_en && (used < DEPTH_W);
    iy                = int'(oy) + int'(ky) - PAD;
    ix                = int'(ox) + int'(kx) - PAD;
`ifdef POOL1_RD_PAD_EN
    pad_slot          = (iy < 0) || (iy >= POOL1_SIZE) || (ix < 0) || (ix >= POOL1_SIZE);
`else
    pad_slot          = 1'b0;
`endif
    last_flag         = (ch == CH_MAX) && (ky == K_MAX) && (kx == K_MAX);
    pass_end          = last_flag && (oy == OUT_MAX) && (ox == OUT_MAX);
    result_bram_ena   = slot && !pad_slot;
    result_bram_addra = '0;
    if (result_bram_ena)
      result_bram_addra = 15'(POOL1_BASE + int'(ch) * POOL1_SIZE * POOL1_SIZE
                              + iy * POOL1_SIZE + ix);
    case (state)
      S_IDLE:  if (pool1_rd_en) state_n = S_ISSUE;
      S_ISSUE: if (slot && pass_end) state_n = S_DRAIN;
      S_DRAIN: if (out_cnt == '0 && fifo_cnt == '0) state_n = S_DONE;
      S_DONE: begin
        pool1_rd_finish = pool1_rd_en;
        if (!pool1_rd_en) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register and the window loop counters. They advance once per slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      {oy, ox, ch, ky, kx} <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && pool1_rd_en) begin
        {oy, ox, ch, ky, kx} <= '0;
      end else if (slot) begin
        if (kx != K_MAX) kx <= kx + 8'd1;
        else begin
          kx <= '0;
          if (ky != K_MAX) ky <= ky + 8'd1;
          else begin
            ky <= '0;
            if (ch != CH_MAX) ch <= ch + 8'd1;
            else begin
              ch <= '0;
              if (ox != OUT_MAX) ox <= ox + 8'd1;
              else begin
                ox <= '0;
                oy <= oy + 8'd1;
              end
            end
          end
        end
      end
    end
  end

  // Read-return pipe: {valid, last} for each slot, with the BRAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v  <= '0;
      pipe_l  <= '0;
`ifdef POOL1_RD_PAD_EN
      pipe_z  <= '0;
`endif
      out_cnt <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_l[i] <= pipe_l[i-1];
`ifdef POOL1_RD_PAD_EN
        pipe_z[i] <= pipe_z[i-1];
`endif
      end
      pipe_v[0] <= slot;
      pipe_l[0] <= last_flag;
`ifdef POOL1_RD_PAD_EN
      pipe_z[0] <= pad_slot;
`endif
      out_cnt <= out_cnt + CW'(slot) - CW'(push);
    end
  end

  // Output FIFO: pushed from the pipe tail and popped on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {pipe_l[RD_LAT-1], push_data};
        wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      end
      if (fifo_pop) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(fifo_pop);
    end
  end

endmodule

// File: tb/tb_pool1_window_reader.sv
// Testbench for pool1_window_reader. The BRAM model returns the low address
// byte after RD_LAT cycles. The expected stream comes from a loop-index golden
// model that feeds an expected queue.
module tb_pool1_window_reader;
  localparam int BASE   = 11520;
  localparam int DEEP   = 20;
  localparam int SIZE   = 12;
  localparam int K      = 5;
  localparam int RD_LAT = 3;
  localparam int DEPTH  = 4;
`ifdef POOL1_RD_PAD_EN
  localparam int PAD = 2;
`else
  localparam int PAD = 0;
`endif
  localparam int OUT   = SIZE - K + 1 + 2 * PAD;
  localparam int WIN   = K * K * DEEP;
  localparam int TOTAL = OUT * OUT * WIN;

  logic        clk = 1'b0;
  logic        rst, pool1_rd_en, result_bram_ena, data_valid, data_ready;
  logic        data_last, pool1_rd_finish;
  logic [14:0] result_bram_addra;
  logic [7:0]  result_bram_douta, data_out;
  logic [1:0]  state_dbg;
  logic [7:0]  rd_q [RD_LAT];
  logic [8:0]  exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  // Clock and reset driving.
  always #5 clk = ~clk;

  pool1_window_reader dut (
    .clk(clk), .rst(rst), .pool1_rd_en(pool1_rd_en),
    .result_bram_ena(result_bram_ena), .result_bram_addra(result_bram_addra),
    .result_bram_douta(result_bram_douta), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .data_last(data_last),
    .pool1_rd_finish(pool1_rd_finish), .state_dbg(state_dbg)
  );

  // BRAM model: mem[a] = a[7:0], read data valid RD_LAT cycles after ena.
  always @(posedge clk) begin
    if (result_bram_ena) rd_q[0] <= result_bram_addra[7:0];
    for (int i = 1; i < RD_LAT; i++) rd_q[i] <= rd_q[i-1];
  end
  assign result_bram_douta = rd_q[RD_LAT-1];

  // Golden address of element idx; -1 for a pad position.
  function automatic int g_addr(input int idx);
    int kx, ky, ch, ox, oy, iy, ix;
    kx = idx % K;
    ky = (idx / K) % K;
    ch = (idx / (K * K)) % DEEP;
    ox = (idx / WIN) % OUT;
    oy = idx / (WIN * OUT);
    iy = oy + ky - PAD;
    ix = ox + kx - PAD;
    if (iy < 0 || iy >= SIZE || ix < 0 || ix >= SIZE) return -1;
    return BASE + ch * SIZE * SIZE + iy * SIZE + ix;
  endfunction

  // Golden {last, data} of element idx.
  function automatic logic [8:0] g_beat(input int idx);
    int a;
    logic [7:0] d;
    logic l;
    a = g_addr(idx);
    d = (a < 0) ? 8'h00 : 8'(a % 256);
    l = ((idx % WIN) == WIN - 1);
    return {l, d};
  endfunction

  function automatic void fill_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(g_beat(i));
  endfunction

  task automatic test_reset();
    rst = 1'b1; pool1_rd_en = 1'b0; data_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    vectors++; if (data_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", data_last); end
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data_out); end
    vectors++; if (result_bram_ena !== 1'b0) begin miscompares++; $display("FAIL reset_ena: got %b want 0", result_bram_ena); end
    vectors++; if (result_bram_addra !== 15'd0) begin miscompares++; $display("FAIL reset_addra: got %0d want 0", result_bram_addra); end
    vectors++; if (pool1_rd_finish !== 1'b0) begin miscompares++; $display("FAIL reset_finish: got %b want 0", pool1_rd_finish); end
    vectors++; if (state_dbg !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++; if (result_bram_ena !== 1'b0) begin miscompares++; $display("FAIL idle_ena: got %b want 0", result_bram_ena); end
    end
  endtask

  // Full pass with ready held high: one slot per cycle, no output bubbles.
  task automatic test_full_pass();
    int beats = 0, slot = 0, cyc = 0;
    logic [8:0] exp;
    fill_exp(TOTAL);
    data_ready = 1'b1;
    @(posedge clk); #1 pool1_rd_en = 1'b1;
    while (beats < TOTAL && cyc < TOTAL + 100) begin
      @(posedge clk); #1; cyc++;
      @(negedge clk);
      if (slot < TOTAL) begin
        vectors++;
        if (result_bram_ena !== (g_addr(slot) >= 0)) begin
          miscompares++; $display("FAIL full_ena slot %0d: got %b want %b", slot, result_bram_ena, g_addr(slot) >= 0);
        end else if (result_bram_ena && result_bram_addra !== 15'(g_addr(slot))) begin
          miscompares++; $display("FAIL full_addra slot %0d: got %0d want %0d", slot, result_bram_addra, g_addr(slot));
        end
        slot++;
      end else begin
        vectors++; if (result_bram_ena !== 1'b0) begin miscompares++; $display("FAIL full_ena_after: got %b want 0", result_bram_ena); end
      end
      if (beats > 0 || data_valid === 1'b1) begin
        vectors++;
        if (data_valid !== 1'b1) begin
          miscompares++; $display("FAIL full_bubble beat %0d: got valid %b want 1", beats, data_valid);
        end else begin
          exp = exp_q.pop_front();
          if ({data_last, data_out} !== exp) begin
            miscompares++; $display("FAIL full_data beat %0d: got %b/%h want %b/%h", beats + 1, data_last, data_out, exp[8], exp[7:0]);
          end
          beats++;
          if (beats == TOTAL) begin
            vectors++; if (pool1_rd_finish !== 1'b0) begin miscompares++; $display("FAIL full_finish_early: got %b want 0", pool1_rd_finish); end
          end
        end
      end
    end
    vectors++; if (beats != TOTAL) begin miscompares++; $display("FAIL full_timeout: got %0d beats want %0d", beats, TOTAL); end
    for (int w = 0; w < 20 && pool1_rd_finish !== 1'b1; w++) @(negedge clk);
    vectors++; if (pool1_rd_finish !== 1'b1) begin miscompares++; $display("FAIL full_finish: got %b want 1", pool1_rd_finish); end
    repeat (5) begin
      @(negedge clk);
      vectors++; if (result_bram_ena !== 1'b0 || data_valid !== 1'b0 || pool1_rd_finish !== 1'b1) begin
        miscompares++; $display("FAIL done_hold: got ena %b valid %b finish %b want 0 0 1", result_bram_ena, data_valid, pool1_rd_finish);
      end
    end
    @(posedge clk); #1 pool1_rd_en = 1'b0;
    @(negedge clk);
    vectors++; if (pool1_rd_finish !== 1'b0) begin miscompares++; $display("FAIL finish_drop: got %b want 0", pool1_rd_finish); end
    @(negedge clk);
    vectors++; if (state_dbg !== 2'd0) begin miscompares++; $display("FAIL back_to_idle: got %0d want 0", state_dbg); end
  endtask

  // Random ready with a 10-cycle enable freeze after 1000 beats.
  task automatic test_backpressure_freeze();
    int n = 3000;
    int beats = 0, slot = 0, cyc = 0, issued = 0, accepted = 0, freeze = 0;
    bit froze = 0, frz_last;
    logic stall_prev = 1'b0;
    logic [8:0] held = '0, exp;
    fill_exp(n);
    @(posedge clk); #1 pool1_rd_en = 1'b1;
    while (beats < n && cyc < 20 * n) begin
      @(posedge clk); #1; cyc++;
      if (!froze && beats >= 1000) begin froze = 1; freeze = 10; end
      frz_last = (freeze == 1);
      if (freeze > 0) begin
        pool1_rd_en = 1'b0; data_ready = 1'b1; freeze--;
      end else begin
        pool1_rd_en = 1'b1; data_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (pool1_rd_en == 1'b0) begin
        vectors++; if (result_bram_ena !== 1'b0) begin miscompares++; $display("FAIL freeze_ena: got %b want 0", result_bram_ena); end
      end
      if (frz_last) begin
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL freeze_drain: got valid %b want 0", data_valid); end
      end
      if (result_bram_ena === 1'b1) begin
        while (g_addr(slot) < 0) slot++;
        vectors++;
        if (result_bram_addra !== 15'(g_addr(slot))) begin
          miscompares++; $display("FAIL bp_addra slot %0d: got %0d want %0d", slot, result_bram_addra, g_addr(slot));
        end
        slot++; issued++;
      end
      if (stall_prev) begin
        vectors++;
        if (data_valid !== 1'b1 || {data_last, data_out} !== held) begin
          miscompares++; $display("FAIL bp_stable: got %b %b/%h want 1 %b/%h", data_valid, data_last, data_out, held[8], held[7:0]);
        end
      end
      stall_prev = data_valid && !data_ready;
      held = {data_last, data_out};
      if (data_valid === 1'b1 && data_ready) begin
        exp = exp_q.pop_front();
        vectors++;
        if ({data_last, data_out} !== exp) begin
          miscompares++; $display("FAIL bp_data beat %0d: got %b/%h want %b/%h", beats + 1, data_last, data_out, exp[8], exp[7:0]);
        end
        beats++; accepted++;
      end
      vectors++;
      if (issued - accepted > DEPTH) begin
        miscompares++; $display("FAIL bp_credit: got %0d in flight want <= %0d", issued - accepted, DEPTH);
      end
    end
    vectors++; if (beats != n) begin miscompares++; $display("FAIL bp_timeout: got %0d beats want %0d", beats, n); end
  endtask

  // Reset after 1234 accepted elements, then a clean restart.
  task automatic test_reset_mid();
    int beats = 0, cyc = 0, slot = 0;
    logic [8:0] exp;
    @(posedge clk); #1 rst = 1'b1; pool1_rd_en = 1'b0; data_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    fill_exp(1234);
    @(posedge clk); #1 pool1_rd_en = 1'b1;
    while (beats < 1234 && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      @(negedge clk);
      if (data_valid === 1'b1) begin
        exp = exp_q.pop_front();
        vectors++;
        if ({data_last, data_out} !== exp) begin
          miscompares++; $display("FAIL pre_reset_data beat %0d: got %h want %h", beats + 1, {data_last, data_out}, exp);
        end
        beats++;
      end
    end
    vectors++; if (beats != 1234) begin miscompares++; $display("FAIL pre_reset_timeout: got %0d want 1234", beats); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid: got %b want 0", data_valid); end
    vectors++; if (data_last !== 1'b0) begin miscompares++; $display("FAIL mid_reset_last: got %b want 0", data_last); end
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL mid_reset_data: got %h want 00", data_out); end
    vectors++; if (result_bram_ena !== 1'b0 || result_bram_addra !== 15'd0) begin
      miscompares++; $display("FAIL mid_reset_bram: got ena %b addra %0d want 0 0", result_bram_ena, result_bram_addra);
    end
    vectors++; if (pool1_rd_finish !== 1'b0) begin miscompares++; $display("FAIL mid_reset_finish: got %b want 0", pool1_rd_finish); end
    vectors++; if (state_dbg !== 2'd0) begin miscompares++; $display("FAIL mid_reset_state: got %0d want 0", state_dbg); end
    #1 rst = 1'b0; pool1_rd_en = 1'b0;
    fill_exp(60);
    beats = 0; cyc = 0;
    @(posedge clk); #1 pool1_rd_en = 1'b1;
    while (beats < 60 && cyc < 500) begin
      @(posedge clk); #1; cyc++;
      @(negedge clk);
      if (result_bram_ena === 1'b1) begin
        while (g_addr(slot) < 0) slot++;
        vectors++;
        if (result_bram_addra !== 15'(g_addr(slot))) begin
          miscompares++; $display("FAIL restart_addra slot %0d: got %0d want %0d", slot, result_bram_addra, g_addr(slot));
        end
        slot++;
      end
      if (data_valid === 1'b1) begin
        exp = exp_q.pop_front();
        vectors++;
        if ({data_last, data_out} !== exp) begin
          miscompares++; $display("FAIL restart_data beat %0d: got %h want %h", beats + 1, {data_last, data_out}, exp);
        end
        beats++;
      end
    end
    vectors++; if (beats != 60) begin miscompares++; $display("FAIL restart_timeout: got %0d want 60", beats); end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_backpressure_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
